// File: rtl/o_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// o_buffer_ctrl
//
// Sequencer for the output-buffer subsystem (accumulator + output RAM bank).
// Processes one output tile per start pulse:
//   CLEAR    -> one-cycle accumulator clear
//   ACCUM    -> WS: accumulate K passes of row results; OS: write rows straight
//               through to the output RAMs
//   DRAIN    -> WS only: drain the accumulator into the output RAMs
//   RD_*     -> read the tile back row-major and stream it over valid/ready
//   FIN      -> completion; done pulses on the following (IDLE) cycle
//
// Optional feature macro: O_BUFFER_CTRL_PERF_EN
//   When defined, adds perf_cycles (cycles from start acceptance to done,
//   inclusive) and perf_stalls (RD_OUT cycles with out_ready low).
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   start, cfg_*          tile launch pulse and configuration (latched in IDLE)
//   in_valid              systolic-array row result valid
//   busy, done            status: high outside IDLE / one-cycle completion pulse
//   acc_reset, idx_gen_on accumulator clear / index-generator enable
//   drain, ag_o_on        accumulator drain / output address-generator enable
//   ram_reset             reserved, tied low
//   mode, num_cols,
//   base_addr             latched configuration for the buffer top
//   ram_idx, read_addr    readback RAM select and address
//   data_read             RAM read data (1-cycle latency)
//   out_data, out_valid,
//   out_ready             streaming readback port
// -----------------------------------------------------------------------------
module o_buffer_ctrl #(
  parameter int ARRAY_M    = 8,
  parameter int RAM_SIZE   = 256,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PASS_WIDTH = 8,
  localparam int CW = $clog2(ARRAY_M) + 1,
  localparam int RW = $clog2(DEPTH) + 1,
  localparam int IW = $clog2(ARRAY_M)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cfg_mode,
  input  logic [CW-1:0]         cfg_num_cols,
  input  logic [RW-1:0]         cfg_num_rows,
  input  logic [PASS_WIDTH-1:0] cfg_num_passes,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                  in_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  acc_reset,
  output logic                  ram_reset,
  output logic                  idx_gen_on,
  output logic                  drain,
  output logic                  ag_o_on,
  output logic                  mode,
  output logic [CW-1:0]         num_cols,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic [IW-1:0]         ram_idx,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] data_read,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef O_BUFFER_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stalls
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_FIN
  } state_t;

  state_t                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [CW-1:0]           num_cols_q, num_cols_d;
  logic [RW-1:0]           num_rows_q, num_rows_d;
  logic [PASS_WIDTH-1:0]   num_passes_q, num_passes_d;
  logic [ADDR_WIDTH-1:0]   base_addr_q, base_addr_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [PASS_WIDTH-1:0]   pass_q, pass_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    done_q, done_d;

  logic [PASS_WIDTH-1:0]   eff_passes;
  logic                    last_row;
  logic                    last_col;
  logic                    last_pass;

  // A pass count of zero behaves like a single pass.
  assign eff_passes = (num_passes_q == '0) ? PASS_WIDTH'(1) : num_passes_q;
  // These compares are only consulted in states reachable with non-zero
  // rows/cols, so the subtraction never underflows in a meaningful path.
  assign last_row   = (row_q == num_rows_q - RW'(1));
  assign last_col   = (col_q == num_cols_q - CW'(1));
  assign last_pass  = (pass_q == eff_passes - PASS_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      num_cols_q   <= '0;
      num_rows_q   <= '0;
      num_passes_q <= '0;
      base_addr_q  <= '0;
      row_q        <= '0;
      col_q        <= '0;
      pass_q       <= '0;
      out_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      num_cols_q   <= num_cols_d;
      num_rows_q   <= num_rows_d;
      num_passes_q <= num_passes_d;
      base_addr_q  <= base_addr_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pass_q       <= pass_d;
      out_data_q   <= out_data_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    num_cols_d   = num_cols_q;
    num_rows_d   = num_rows_q;
    num_passes_d = num_passes_q;
    base_addr_d  = base_addr_q;
    row_d        = row_q;
    col_d        = col_q;
    pass_d       = pass_q;
    out_data_d   = out_data_q;
    done_d       = 1'b0;
    acc_reset    = 1'b0;
    idx_gen_on   = 1'b0;
    drain        = 1'b0;
    ag_o_on      = 1'b0;
    out_valid    = 1'b0;
    read_addr    = '0;
    ram_idx      = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d       = cfg_mode;
          num_cols_d   = cfg_num_cols;
          num_rows_d   = cfg_num_rows;
          num_passes_d = cfg_num_passes;
          base_addr_d  = cfg_base_addr;
          row_d        = '0;
          col_d        = '0;
          pass_d       = '0;
          // Empty tile: nothing to accumulate or read back.
          if (cfg_num_cols == '0 || cfg_num_rows == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end

      S_CLEAR: begin
        acc_reset = 1'b1;
        state_d   = S_ACCUM;
      end

      S_ACCUM: begin
        if (mode_q) begin
          // OS: rows go straight to the RAMs as they arrive.
          ag_o_on = in_valid;
          if (in_valid) begin
            if (last_row) begin
              row_d   = '0;
              state_d = S_RD_ISSUE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end
        end else begin
          idx_gen_on = in_valid;
          if (in_valid) begin
            if (last_row) begin
              row_d = '0;
              if (last_pass) begin
                pass_d  = '0;
                state_d = S_DRAIN;
              end else begin
                pass_d = pass_q + PASS_WIDTH'(1);
              end
            end else begin
              row_d = row_q + RW'(1);
            end
          end
        end
      end

      S_DRAIN: begin
        // The buffer top delays ag_o_on itself to line up with drain data.
        drain   = 1'b1;
        ag_o_on = 1'b1;
        if (last_row) begin
          row_d   = '0;
          state_d = S_RD_ISSUE;
        end else begin
          row_d = row_q + RW'(1);
        end
      end

      S_RD_ISSUE: begin
        // Address wraps modulo RAM_SIZE through the natural adder width.
        read_addr = base_addr_q + ADDR_WIDTH'(row_q);
        ram_idx   = col_q[IW-1:0];
        state_d   = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        out_data_d = data_read;
        state_d    = S_RD_OUT;
      end

      S_RD_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = S_FIN;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = S_RD_ISSUE;
            end
          end else begin
            col_d   = col_q + CW'(1);
            state_d = S_RD_ISSUE;
          end
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign ram_reset = 1'b0;
  assign mode      = mode_q;
  assign num_cols  = num_cols_q;
  assign base_addr = base_addr_q;
  assign out_data  = out_data_q;

`ifdef O_BUFFER_CTRL_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stalls_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      // The acceptance cycle itself is the first counted cycle.
      perf_cycles_q <= 32'd1;
      perf_stalls_q <= '0;
    end else begin
      // Busy cycles plus the trailing done cycle; held afterwards.
      if (busy || done_q) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (state_q == S_RD_OUT && !out_ready) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_o_buffer_ctrl.sv
`timescale 1ns/1ps
module tb_o_buffer_ctrl;

  localparam int CW = 4;
  localparam int RW = 4;
  localparam int IW = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          cfg_mode = 1'b0;
  logic [CW-1:0] cfg_num_cols = '0;
  logic [RW-1:0] cfg_num_rows = '0;
  logic [PW-1:0] cfg_num_passes = '0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] data_read;
  logic          busy, done, acc_reset, ram_reset, idx_gen_on, drain, ag_o_on;
  logic          mode, out_valid;
  logic [CW-1:0] num_cols;
  logic [AW-1:0] base_addr, read_addr;
  logic [IW-1:0] ram_idx;
  logic [DW-1:0] out_data;
`ifdef O_BUFFER_CTRL_PERF_EN
  logic [31:0]   perf_cycles, perf_stalls;
`endif

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] all_out;
  assign all_out = {busy, done, acc_reset, ram_reset, idx_gen_on, drain, ag_o_on,
                    mode, num_cols, base_addr, ram_idx, read_addr, out_data, out_valid};

  o_buffer_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
    .cfg_num_cols(cfg_num_cols), .cfg_num_rows(cfg_num_rows),
    .cfg_num_passes(cfg_num_passes), .cfg_base_addr(cfg_base_addr),
    .in_valid(in_valid), .busy(busy), .done(done), .acc_reset(acc_reset),
    .ram_reset(ram_reset), .idx_gen_on(idx_gen_on), .drain(drain),
    .ag_o_on(ag_o_on), .mode(mode), .num_cols(num_cols), .base_addr(base_addr),
    .ram_idx(ram_idx), .read_addr(read_addr), .data_read(data_read),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef O_BUFFER_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: word tags its own RAM index and address, 1-cycle read latency.
  always @(posedge clk) data_read <= {5'd0, ram_idx, read_addr, 16'hBEEF};

  typedef struct {
    int acc, idx, drn, ago, dn, done_at, words, werr, ovn;
    int stalls, serr, iverr, agoerr, rz_err, rst_done, rst_k;
    logic bsy_at_done;
  } stats_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ev: 0 none, 1 spurious start at cycle 2, 2 reset on first out_valid.
  task automatic run_tile(input logic md, input int cols, input int rows, input int passes,
                          input logic [7:0] base, input int iv_mode, input int or_mode,
                          input int ev, input int budget, output stats_t s);
    logic [5:0]  ivp;
    logic [3:0]  orp;
    logic        pv_stall;
    logic [31:0] pv_data;
    logic [31:0] expw;
    logic        rst_pending;
    int          w;
    s = '{default: 0};
    s.done_at = -1;
    ivp = 6'b101101;
    orp = 4'b1001;
    pv_stall = 1'b0;
    pv_data = '0;
    rst_pending = 1'b0;
    w = 0;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_mode = md;
    cfg_num_cols = CW'(cols);
    cfg_num_rows = RW'(rows);
    cfg_num_passes = PW'(passes);
    cfg_base_addr = base;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (rst_pending) begin
        if (all_out !== 64'd0) s.rz_err++;
        reset = 1'b1;
        rst_pending = 1'b0;
        s.rst_done = 1;
        s.rst_k = k;
      end
      start = 1'b0;
      if (ev == 1 && k == 2) begin
        start = 1'b1;
        cfg_mode = ~md;
        cfg_num_cols = CW'(7);
        cfg_num_rows = RW'(5);
        cfg_base_addr = 8'h99;
      end
      in_valid  = (iv_mode == 0) ? 1'b1 : ivp[k % 6];
      out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? orp[k % 4] : 1'b0;
      #1;
      s.acc += int'(acc_reset);
      s.idx += int'(idx_gen_on);
      if (idx_gen_on && !in_valid) s.iverr++;
      s.drn += int'(drain);
      s.ago += int'(ag_o_on);
      if (md && ag_o_on && !in_valid) s.agoerr++;
      s.ovn += int'(out_valid);
      if (pv_stall && (!out_valid || out_data !== pv_data)) s.serr++;
      if (out_valid && !out_ready) s.stalls++;
      pv_stall = out_valid && !out_ready;
      pv_data = out_data;
      if (out_valid && out_ready) begin
        if (w >= cols * rows) begin
          s.werr++;
        end else begin
          expw = {8'(w % cols), base + 8'(w / cols), 16'hBEEF};
          if (out_data !== expw) s.werr++;
        end
        w++;
      end
      if (done) begin
        s.dn++;
        if (s.done_at < 0) begin
          s.done_at = k;
          s.bsy_at_done = busy;
        end
      end
      if (ev == 2 && s.rst_done == 0 && !rst_pending && out_valid) begin
        reset = 1'b0;
        rst_pending = 1'b1;
      end
      if (s.done_at >= 0 && k >= s.done_at + 2) break;
      if (s.rst_done != 0 && k >= s.rst_k + 10) break;
    end
    s.words = w;
    in_valid = 1'b0;
    out_ready = 1'b0;
    $display("tile mode=%0d cols=%0d rows=%0d passes=%0d base=%0h: words=%0d done_at=%0d idx=%0d drain=%0d ago=%0d stalls=%0d",
             md, cols, rows, passes, base, s.words, s.done_at, s.idx, s.drn, s.ago, s.stalls);
  endtask

  stats_t st;

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_out, 64'd0);
    reset = 1'b1;

    // WS 8x8, two passes, continuous input
    run_tile(1'b0, 8, 8, 2, 8'h10, 0, 0, 0, 600, st);
    check("ws_acc_reset", st.acc, 1);
    check("ws_idx_gen", st.idx, 16);
    check("ws_drain", st.drn, 8);
    check("ws_ag_o_on", st.ago, 8);
    check("ws_words", st.words, 64);
    check("ws_word_err", st.werr, 0);
    check("ws_done_cnt", st.dn, 1);
    check("ws_done_at", st.done_at, 219);
    check("ws_busy_at_done", st.bsy_at_done, 1'b0);
`ifdef O_BUFFER_CTRL_PERF_EN
    check("ws_perf_cycles", perf_cycles, 220);
`endif

    // OS 4x3 with address wrap, gapped input
    run_tile(1'b1, 4, 3, 5, 8'hFE, 1, 0, 0, 400, st);
    check("os_idx_gen", st.idx, 0);
    check("os_drain", st.drn, 0);
    check("os_ag_o_on", st.ago, 3);
    check("os_ag_mirror", st.agoerr, 0);
    check("os_words", st.words, 12);
    check("os_word_err", st.werr, 0);
    check("os_done_at", st.done_at, 43);

    // Backpressure, passes=0 treated as one pass
    run_tile(1'b0, 2, 2, 0, 8'h40, 0, 1, 0, 400, st);
    check("bp_idx_gen", st.idx, 2);
    check("bp_drain", st.drn, 2);
    check("bp_words", st.words, 4);
    check("bp_word_err", st.werr, 0);
    check("bp_stable", st.serr, 0);
    check("bp_stalls", st.stalls, 2);
    check("bp_done_at", st.done_at, 21);
`ifdef O_BUFFER_CTRL_PERF_EN
    check("bp_perf_stalls", perf_stalls, 2);
`endif

    // Empty tiles
    run_tile(1'b0, 0, 3, 1, 8'h00, 0, 0, 0, 50, st);
    check("e0c_done_at", st.done_at, 2);
    check("e0c_done_cnt", st.dn, 1);
    check("e0c_quiet", st.ago + st.drn + st.ovn + st.acc, 0);
`ifdef O_BUFFER_CTRL_PERF_EN
    check("e0c_perf_cycles", perf_cycles, 3);
`endif
    run_tile(1'b1, 4, 0, 1, 8'h00, 0, 0, 0, 50, st);
    check("e0r_done_at", st.done_at, 2);
    check("e0r_quiet", st.ago + st.drn + st.ovn + st.acc, 0);

    // WS gapped input: passes advance only on valid beats
    run_tile(1'b0, 1, 3, 2, 8'h00, 1, 0, 0, 200, st);
    check("gap_idx_gen", st.idx, 6);
    check("gap_idx_only_valid", st.iverr, 0);
    check("gap_drain", st.drn, 3);
    check("gap_words", st.words, 3);
    check("gap_word_err", st.werr, 0);

    // Spurious start during ACCUM
    run_tile(1'b0, 2, 2, 1, 8'h20, 0, 0, 1, 200, st);
    check("ign_mode", mode, 1'b0);
    check("ign_num_cols", num_cols, 4'd2);
    check("ign_base", base_addr, 8'h20);
    check("ign_words", st.words, 4);
    check("ign_word_err", st.werr, 0);
    check("ign_done_cnt", st.dn, 1);

    // Reset while in RD_OUT
    run_tile(1'b1, 3, 2, 1, 8'h33, 0, 2, 2, 100, st);
    check("rst_fired", st.rst_done, 1);
    check("rst_all_zero", st.rz_err, 0);
    check("rst_no_done", st.dn, 0);
    check("rst_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
